// File: rtl/serial_pkg.sv
// Shared definitions for the serial receive/transmit buffer stages.
package serial_pkg;

   localparam int unsigned SER_DATA_W = 8;

   typedef enum logic {
      CAP_IDLE = 1'b0,
      CAP_ACK  = 1'b1
   } cap_state_e;

   // Ceiling log2, used to derive pointer widths from entry counts.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) res = i + 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with registered count and flags.
module sync_fifo
   import serial_pkg::*;
#(
   parameter int unsigned WIDTH      = SER_DATA_W,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned ADDR_WIDTH = clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [WIDTH-1:0]      din,
   output logic [WIDTH-1:0]      dout,
   output logic                  empty,
   output logic                  full,
   output logic [ADDR_WIDTH:0]   count
);

   localparam int unsigned CNT_W = ADDR_WIDTH + 1;

   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  empty_q, full_q;
   logic                  do_rd_c, do_wr_c;

   // A pop frees the slot a same-cycle push needs when full.
   always_comb begin
      do_rd_c  = rd_en && !empty_q;
      do_wr_c  = wr_en && (!full_q || do_rd_c);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_wr_c) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      if (do_rd_c) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      case ({do_wr_c, do_rd_c})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         empty_q  <= (count_d == CNT_W'(0));
         full_q   <= (count_d == CNT_W'(DEPTH));
      end
   end

   // Storage needs no reset; the output is masked while empty.
   always_ff @(posedge clk) begin
      if (do_wr_c) mem_q[wr_ptr_q] <= din;
   end

   assign dout  = empty_q ? '0 : mem_q[rd_ptr_q];
   assign empty = empty_q;
   assign full  = full_q;
   assign count = count_q;

endmodule

// File: rtl/serial_rx_fifo.sv
// UART receive buffer: one capture per ready assertion into a FWFT FIFO,
// with a sticky overflow flag for bytes dropped while full.
module serial_rx_fifo
   import serial_pkg::*;
#(
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned ADDR_WIDTH = clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [SER_DATA_W-1:0] ser_dat,
   input  logic                  ser_ready,
   output logic                  ser_ready_rst,
   input  logic                  rd_en,
   output logic [SER_DATA_W-1:0] rd_data,
   output logic                  empty,
   output logic                  full,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   input  logic                  ovf_clr
);

   cap_state_e state_q, state_d;
   logic       ser_ready_rst_q, ser_ready_rst_d;
   logic       overflow_q, overflow_d;
   logic       capture_c, drop_c;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= CAP_IDLE;
         ser_ready_rst_q <= 1'b0;
         overflow_q      <= 1'b0;
      end else begin
         state_q         <= state_d;
         ser_ready_rst_q <= ser_ready_rst_d;
         overflow_q      <= overflow_d;
      end
   end

   // Hold ACK until the core drops ready so a lingering flag is not recaptured.
   always_comb begin
      state_d    = state_q;
      capture_c  = 1'b0;
      drop_c     = 1'b0;
      overflow_d = overflow_q;
      case (state_q)
         CAP_IDLE: begin
            if (ser_ready) begin
               capture_c = 1'b1;
               state_d   = CAP_ACK;
            end
         end
         CAP_ACK: begin
            if (!ser_ready) state_d = CAP_IDLE;
         end
         default: state_d = CAP_IDLE;
      endcase
      ser_ready_rst_d = (state_d == CAP_ACK);
      drop_c          = capture_c && full && !rd_en;
      if (drop_c)       overflow_d = 1'b1;
      else if (ovf_clr) overflow_d = 1'b0;
   end

   sync_fifo #(
      .WIDTH      (SER_DATA_W),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst),
      .wr_en (capture_c),
      .rd_en (rd_en),
      .din   (ser_dat),
      .dout  (rd_data),
      .empty (empty),
      .full  (full),
      .count (count)
   );

   assign ser_ready_rst = ser_ready_rst_q;
   assign overflow      = overflow_q;

endmodule
